// File: rtl/i2c_model_pkg.sv
// Shared types and constants for the i2c_target_model register-pointer target.
package i2c_model_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PTR,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } state_t;

  localparam logic       ACK_BIT          = 1'b0;
  localparam logic       NACK_BIT         = 1'b1;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h40;

  // Bit counter values: 8 = data byte complete (ACK slot pending), 9 = inside ACK slot.
  localparam logic [3:0] BIT_LAST = 4'd7;
  localparam logic [3:0] BIT_ACKP = 4'd8;
  localparam logic [3:0] BIT_ACKS = 4'd9;

endpackage

// File: rtl/i2c_line_sync.sv
// 2-FF synchronizer for the resolved SCL/SDA lines plus edge and START/STOP decode.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized value.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_target_model.sv
// Cycle-based I2C register-pointer target that also resolves the open-drain bus.
// Define I2C_TARGET_STRETCH_EN to hold SCL low for STRETCH_CYCLES after each ACK slot.
module i2c_target_model
  import i2c_model_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
  parameter int         NREGS     = 16,
  parameter logic [7:0] INIT_BASE = 8'hA0
`ifdef I2C_TARGET_STRETCH_EN
  ,
  parameter int         STRETCH_CYCLES = 64
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl_o,
  input  logic       i_scl_oe,
  input  logic       i_sda_o,
  input  logic       i_sda_oe,
  output logic       o_scl_i,
  output logic       o_sda_i,
  output logic       o_wr_stb,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy,
  output logic       o_nack
);

  localparam int PW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t         state;
  state_t         state_next;
  logic [PW-1:0]  ptr;
  logic [7:0]     regs [NREGS];
  logic [3:0]     bit_cnt;
  logic [6:0]     rx_sh;
  logic [7:0]     rx_byte;
  logic [6:0]     tx_sh;
  logic           rw;
  logic           active;
  logic           ctl_scl;
  logic           ctl_sda;
  logic           tgt_scl_low;
  logic           tgt_sda_low;
  logic           sda_s;
  logic           scl_rise;
  logic           scl_fall;
  logic           start_det;
  logic           stop_det;

  assign ctl_scl = ~(i_scl_oe & ~i_scl_o);
  assign ctl_sda = ~(i_sda_oe & ~i_sda_o);
  assign o_scl_i = ctl_scl & ~tgt_scl_low;
  assign o_sda_i = ctl_sda & ~tgt_sda_low;

  i2c_line_sync u_sync (
    .clk       (i_clk),
    .rst       (i_rst),
    .scl       (o_scl_i),
    .sda       (o_sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_byte = {rx_sh, sda_s};
  assign active  = state inside {ST_ADDR, ST_PTR, ST_WRITE, ST_READ};

  always_comb begin
    state_next = state;
    if (start_det) begin
      state_next = ST_ADDR;
    end else if (stop_det) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise && bit_cnt == BIT_LAST && rx_byte[7:1] != DEV_ADDR)
            state_next = ST_IGNORE;
          else if (scl_fall && bit_cnt == BIT_ACKS)
            state_next = rw ? ST_READ : ST_PTR;
        end
        ST_PTR: begin
          if (scl_fall && bit_cnt == BIT_ACKS) state_next = ST_WRITE;
        end
        ST_READ: begin
          if (scl_rise && bit_cnt == BIT_ACKP && sda_s == NACK_BIT) state_next = ST_IGNORE;
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      rw          <= 1'b0;
      tgt_sda_low <= 1'b0;
      o_wr_stb    <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_busy      <= 1'b0;
      o_nack      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= INIT_BASE + 8'(i);
    end else begin
      state    <= state_next;
      o_wr_stb <= 1'b0;
      if (start_det) begin
        bit_cnt     <= '0;
        o_nack      <= 1'b0;
        o_busy      <= 1'b1;
        tgt_sda_low <= 1'b0;
      end else if (stop_det) begin
        bit_cnt     <= '0;
        o_busy      <= 1'b0;
        tgt_sda_low <= 1'b0;
      end else if (active && scl_rise) begin
        if (bit_cnt < BIT_ACKP) begin
          rx_sh   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == BIT_LAST) begin
            case (state)
              ST_ADDR:  rw  <= sda_s;
              ST_PTR:   ptr <= rx_byte[PW-1:0];
              ST_WRITE: begin
                regs[ptr] <= rx_byte;
                o_wr_stb  <= 1'b1;
                o_wr_addr <= 8'(ptr);
                o_wr_data <= rx_byte;
              end
              default: ;
            endcase
          end
        end else if (bit_cnt == BIT_ACKP) begin
          bit_cnt <= BIT_ACKS;
          // Controller's answer to a read byte: ACK advances, NACK ends the burst.
          if (state == ST_READ) begin
            if (sda_s == NACK_BIT) o_nack <= 1'b1;
            else                   ptr    <= ptr + 1'b1;
          end
        end
      end else if (active && scl_fall) begin
        if (bit_cnt == BIT_ACKP) begin
          tgt_sda_low <= (state != ST_READ) ? ~ACK_BIT : 1'b0;
        end else if (bit_cnt == BIT_ACKS) begin
          bit_cnt <= '0;
          if (state == ST_READ || (state == ST_ADDR && rw)) begin
            tx_sh       <= regs[ptr][6:0];
            tgt_sda_low <= ~regs[ptr][7];
          end else begin
            tgt_sda_low <= 1'b0;
          end
          if (state == ST_WRITE) ptr <= ptr + 1'b1;
        end else if (state == ST_READ && bit_cnt != 4'd0) begin
          tx_sh       <= {tx_sh[5:0], 1'b0};
          tgt_sda_low <= ~tx_sh[6];
        end
      end
    end
  end

`ifdef I2C_TARGET_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  logic          ack_end;
  logic [SW-1:0] stretch_cnt;

  assign ack_end = active & scl_fall & (bit_cnt == BIT_ACKS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tgt_scl_low <= 1'b0;
      stretch_cnt <= '0;
    end else if (ack_end) begin
      tgt_scl_low <= 1'b1;
      stretch_cnt <= SW'(STRETCH_CYCLES - 1);
    end else if (tgt_scl_low) begin
      if (stretch_cnt == '0) tgt_scl_low <= 1'b0;
      else                   stretch_cnt <= stretch_cnt - 1'b1;
    end
  end
`else
  assign tgt_scl_low = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_target_model.sv
// Bench for i2c_target_model: bit-banged controller, register-file reference model, write scoreboard.
module tb_i2c_target_model;

  localparam int         Q              = 6;
  localparam int         NREGS          = 16;
  localparam logic [7:0] INIT_BASE      = 8'hA0;
  localparam logic [6:0] DEV            = 7'h40;
  localparam int         STRETCH_CYCLES = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_o, scl_oe, sda_o, sda_oe;
  logic       scl_i, sda_i;
  logic       wr_stb;
  logic [7:0] wr_addr, wr_data;
  logic       busy, nack;

  always #5 clk = ~clk;

  i2c_target_model dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_scl_o   (scl_o),
    .i_scl_oe  (scl_oe),
    .i_sda_o   (sda_o),
    .i_sda_oe  (sda_oe),
    .o_scl_i   (scl_i),
    .o_sda_i   (sda_i),
    .o_wr_stb  (wr_stb),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_busy    (busy),
    .o_nack    (nack)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  m_regs[NREGS];
  int          m_ptr;
  logic        m_nack;
  logic [7:0]  none[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for register writes.
  always @(negedge clk) begin
    if (!rst && wr_stb === 1'b1) begin
      if (exp_q.size() == 0) check_eq("wr_stb_unexpected", wr_stb, 0);
      else                   check_eq("wr_event", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  int scl_diff = 0;
  int cur_low  = 0;
  int max_low  = 0;
  always @(negedge clk) begin
    if (scl_i !== ~(scl_oe & ~scl_o)) scl_diff++;
    if (scl_i === 1'b0) cur_low++;
    else begin
      if (cur_low > max_low) max_low = cur_low;
      cur_low = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scl_release();
    int waited = 0;
    scl_oe = 1'b0;
    #1;
    while (scl_i !== 1'b1 && waited < 400) begin
      tick(1);
      waited++;
    end
    if (waited >= 400) check_eq("scl_release_timeout", scl_i, 1);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_oe = ~b;
    tick(Q);
    scl_release();
    tick(Q);
    s = sda_i;
    tick(Q);
    scl_oe = 1'b1;
    tick(Q);
  endtask

  task automatic bus_start();
    sda_oe = 1'b0;
    tick(Q);
    scl_release();
    tick(Q);
    sda_oe = 1'b1;
    tick(Q);
    scl_oe = 1'b1;
    tick(Q);
    m_nack = 1'b0;
  endtask

  task automatic bus_stop();
    sda_oe = 1'b1;
    tick(Q);
    scl_release();
    tick(Q);
    sda_oe = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic give_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      b[i] = s;
    end
    bit_xfer(give_ack ? 1'b0 : 1'b1, s);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = INIT_BASE + 8'(i);
    m_ptr  = 0;
    m_nack = 1'b0;
  endtask

  task automatic txn_write(input logic [7:0] p, input logic [7:0] d[$], input bit stop_after);
    logic a;
    bus_start();
    send_byte({DEV, 1'b0}, a);
    check_eq("wr_addr_ack", a, 0);
    check_eq("busy_in_txn", busy, 1);
    send_byte(p, a);
    check_eq("ptr_ack", a, 0);
    m_ptr = p % NREGS;
    foreach (d[i]) begin
      exp_q.push_back({8'(m_ptr), d[i]});
      m_regs[m_ptr] = d[i];
      m_ptr = (m_ptr + 1) % NREGS;
      send_byte(d[i], a);
      check_eq("data_ack", a, 0);
    end
    if (stop_after) begin
      bus_stop();
      check_eq("busy_after_stop", busy, 0);
    end
  endtask

  task automatic txn_read(input int n);
    logic       a;
    logic [7:0] b;
    bus_start();
    send_byte({DEV, 1'b1}, a);
    check_eq("rd_addr_ack", a, 0);
    for (int k = 0; k < n; k++) begin
      recv_byte(k != n - 1, b);
      check_eq("rd_data", b, m_regs[m_ptr]);
      if (k != n - 1) m_ptr = (m_ptr + 1) % NREGS;
      else            m_nack = 1'b1;
    end
    check_eq("nack_flag", nack, m_nack);
    bus_stop();
    check_eq("sda_released", sda_i, 1);
    check_eq("busy_after_stop", busy, 0);
  endtask

  task automatic txn_bad(input logic [6:0] addr, input logic rwb);
    logic a;
    bus_start();
    send_byte({addr, rwb}, a);
    check_eq("bad_addr_noack", a, 1);
    check_eq("bad_addr_busy", busy, 1);
    send_byte(8'($urandom), a);
    check_eq("bad_data_noack", a, 1);
    bus_stop();
    check_eq("bad_busy_after_stop", busy, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] dq[$];
    logic       s;
    int         zeros;
    rst = 1'b1;
    scl_o = 1'b0; sda_o = 1'b0; scl_oe = 1'b0; sda_oe = 1'b0;
    model_reset();
    tick(4);
    rst = 1'b0;
    tick(2);
    check_eq("rst_scl", scl_i, 1);
    check_eq("rst_sda", sda_i, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_nack", nack, 0);
    check_eq("rst_wr_stb", wr_stb, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);

    // Set pointer, repeated START, read three bytes ending with NACK.
    txn_write(8'h02, none, 1'b0);
    txn_read(3);

    dq = '{8'h5A, 8'hC3};
    txn_write(8'h03, dq, 1'b1);

    txn_bad(7'h21, 1'b0);

    // Pointer wrap at the top of the register file.
    dq = '{8'h11, 8'h22};
    txn_write(8'h0F, dq, 1'b1);
    txn_write(8'h00, none, 1'b0);
    txn_read(1);

    // Reset in the middle of a read data byte.
    txn_write(8'h05, none, 1'b0);
    bus_start();
    send_byte({DEV, 1'b1}, s);
    check_eq("rst_test_addr_ack", s, 0);
    bit_xfer(1'b1, s);
    check_eq("rst_test_bit7", s, m_regs[5][7]);
    sda_oe = 1'b0;
    tick(Q);
    scl_release();
    tick(Q);
    check_eq("rst_test_bit6", sda_i, m_regs[5][6]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_test_sda_release", sda_i, 1);
    rst = 1'b0;
    model_reset();
    tick(Q);
    scl_oe = 1'b1;
    tick(Q);
    zeros = 0;
    for (int i = 0; i < 9; i++) begin
      bit_xfer(1'b1, s);
      if (s !== 1'b1) zeros++;
    end
    check_eq("post_rst_sda_idle", zeros, 0);
    check_eq("post_rst_busy", busy, 0);
    bus_stop();
    txn_read(1);

    for (int t = 0; t < 16; t++) begin
      int op;
      int n;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          dq = {};
          n = $urandom_range(0, 3);
          for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
          txn_write(8'($urandom_range(0, 255)), dq, 1'b1);
        end
        1: begin
          txn_write(8'($urandom_range(0, 255)), none, 1'b0);
          txn_read($urandom_range(1, 4));
        end
        2: txn_read($urandom_range(1, 4));
        default: begin
          logic [6:0] ba;
          ba = 7'($urandom_range(0, 127));
          if (ba == DEV) ba = ba ^ 7'h01;
          txn_bad(ba, 1'($urandom));
        end
      endcase
      check_eq("rand_nack", nack, m_nack);
    end

    tick(4);
    check_eq("wr_queue_drained", exp_q.size(), 0);
`ifdef I2C_TARGET_STRETCH_EN
    check_eq("stretch_len", max_low, STRETCH_CYCLES + 3);
`else
    check_eq("scl_passthrough", scl_diff, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
